seg_scan_display: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for NUM_DIGITS common-anode digits.
- Features: hex decode, per-digit decimal point and blanking, PWM brightness, an anti-ghosting guard interval at each digit switch, and a double-buffered load so every scan frame shows one coherent value.
- Sits between application logic (score, timer, and similar counters) and the board's segment/anode pins.
- Replaces the fixed 4-digit scanner in new designs.

---
 rtl/seg_scan_pkg.sv | 20 ++
 rtl/hex_to_seg.sv | 13 +
 rtl/seg_scan_display.sv | 139 +++++++++++++
 tb/tb_seg_scan_display.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SEG_OFF    : all segments dark (active-low).
//   SEG_TABLE  : hex nibble -> active-low segments, bit 0 = a ... bit 6 = g.
//   idx_width  : counter width for a modulus n (never less than 1 bit).
package seg_scan_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,  // 0 1 2 3
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,  // 4 5 6 7
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,  // 8 9 A b
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110   // C d E F
  };

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : hex digit to show.
//   seg    : active-low segment pattern, seg[0]=a ... seg[6]=g.
module hex_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode seven-segment driver with PWM brightness,
// anti-ghosting guard interval and a double-buffered load.
//   clk, rst_l   : clock; asynchronous active-high reset.
//   digits_in    : one hex nibble per digit, digit k at [4k+3:4k].
//   dp_in        : decimal point per digit, 1 = lit.
//   blank_in     : 1 = digit dark.
//   load         : one-cycle strobe capturing the three inputs into the shadow.
//   brightness   : 0 = off, all ones = brightest.
//   pending      : shadow holds data not yet shown.
//   seg, dp, an  : active-low segments, decimal point and anodes (registered).
//   frame_tick   : one-cycle pulse after the last slot of each frame.
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 25000,
  parameter int unsigned BLANK_CYC  = 16,
  parameter int unsigned BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic                    pending,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned CW   = idx_width(DIV);
  localparam int unsigned IW   = idx_width(NUM_DIGITS);
  localparam logic [31:0] SPAN = 32'(DIV - BLANK_CYC);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [BRIGHT_W-1:0]     bright_q;

  logic [4*NUM_DIGITS-1:0] act_digits, sh_digits;
  logic [NUM_DIGITS-1:0]   act_dp, act_blank, sh_dp, sh_blank;

  logic                    cnt_wrap, frame_end, slot_on, lit;
  logic [BRIGHT_W-1:0]     bright_eff;
  logic [31:0]             cnt_ext, on_len;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   an_onehot;

  assign cnt_wrap  = (cnt == CW'(DIV - 1));
  assign frame_end = cnt_wrap && (idx == IW'(NUM_DIGITS - 1));

  // The slot that is just starting must already see the freshly sampled
  // brightness, so bypass the register on cnt==0.
  assign bright_eff = (cnt == '0) ? brightness : bright_q;
  assign cnt_ext    = 32'(cnt);
  assign on_len     = (SPAN * 32'(bright_eff)) >> BRIGHT_W;
  assign slot_on    = (cnt_ext >= BLANK_CYC) && ((cnt_ext - BLANK_CYC) < on_len);
  assign lit        = slot_on && !act_blank[idx];
  assign nibble     = act_digits[{idx, 2'b00} +: 4];

  // NOTE: every always_comb output gets a default before any conditional
  // write, otherwise synthesis infers a latch for the unwritten bits.
  always_comb begin
    an_onehot      = '0;
    an_onehot[idx] = 1'b1;
  end

  hex_to_seg u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the shadow/active buffers are small
  // registers (not RAM) and are reset so a reset discards stale data.
  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      cnt        <= '0;
      idx        <= '0;
      bright_q   <= '0;
      act_digits <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      pending    <= 1'b0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap) begin
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end
      if (cnt == '0) begin
        bright_q <= brightness;
      end

      if (lit) begin
        an  <= ~an_onehot;
        seg <= dec_seg;
        dp  <= ~act_dp[idx];
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
      frame_tick <= frame_end;

      if (load) begin
        sh_digits <= digits_in;
        sh_dp     <= dp_in;
        sh_blank  <= blank_in;
        pending   <= 1'b1;
      end
      // A load landing on the frame-end cycle bypasses the shadow so the
      // newest value is never held back a whole frame.
      if (frame_end) begin
        if (load) begin
          act_digits <= digits_in;
          act_dp     <= dp_in;
          act_blank  <= blank_in;
          pending    <= 1'b0;
        end else if (pending) begin
          act_digits <= sh_digits;
          act_dp     <= sh_dp;
          act_blank  <= sh_blank;
          pending    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display. The driver advances a
// time-based reference model one cycle at a time and queues the expected
// outputs; a monitor on the falling edge pops and compares.
module tb_seg_scan_display;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int BW    = 2;
  localparam int FRAME = N * DIV;

  logic          clk = 1'b0;
  logic          rst_l = 1'b1;
  logic [15:0]   digits_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic          load = 1'b0;
  logic [BW-1:0] brightness = '0;
  logic          pending;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_tick;

  seg_scan_display #(
    .NUM_DIGITS (N),
    .DIV        (DIV),
    .BLANK_CYC  (BLANK),
    .BRIGHT_W   (BW)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .brightness (brightness),
    .pending    (pending),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    logic       pend;
  } obs_t;

  // Segment patterns written out from the decode table (gfedcba, active-low).
  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  obs_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: absolute cycle count since reset release plus the
  // displayed / staged frame contents.
  int unsigned m_n;
  int          m_bright;
  logic [3:0]  m_act_dig [N];
  bit          m_act_dp [N];
  bit          m_act_blank [N];
  logic [3:0]  m_sh_dig [N];
  bit          m_sh_dp [N];
  bit          m_sh_blank [N];
  bit          m_pend;

  function automatic void model_reset();
    m_n      = 0;
    m_bright = 0;
    m_pend   = 0;
    for (int k = 0; k < N; k++) begin
      m_act_dig[k]   = 4'h0;
      m_act_dp[k]    = 1'b0;
      m_act_blank[k] = 1'b1;
      m_sh_dig[k]    = 4'h0;
      m_sh_dp[k]     = 1'b0;
      m_sh_blank[k]  = 1'b0;
    end
  endfunction

  // Predict the outputs following the next rising edge, queue them, then
  // let that edge happen.
  task automatic step();
    obs_t       e;
    int         pos, dig, on_len;
    bit         fe, lit;
    logic [3:0] oh;
    if (rst_l) begin
      model_reset();
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0, pend: 1'b0};
    end else begin
      pos = int'(m_n % DIV);
      dig = int'((m_n / DIV) % N);
      fe  = (pos == DIV - 1) && (dig == N - 1);
      if (pos == 0) m_bright = int'(brightness);
      on_len = ((DIV - BLANK) * m_bright) / (1 << BW);
      lit = (pos >= BLANK) && (pos - BLANK < on_len) && !m_act_blank[dig];
      oh = 4'b0000;
      oh[dig] = 1'b1;
      e.an   = lit ? ~oh : 4'hF;
      e.seg  = lit ? seg_ref[m_act_dig[dig]] : 7'h7F;
      e.dp   = lit ? ~m_act_dp[dig] : 1'b1;
      e.tick = fe;
      if (load) begin
        for (int k = 0; k < N; k++) begin
          m_sh_dig[k]   = digits_in[4*k +: 4];
          m_sh_dp[k]    = dp_in[k];
          m_sh_blank[k] = blank_in[k];
        end
        m_pend = 1'b1;
      end
      if (fe && m_pend) begin
        m_act_dig   = m_sh_dig;
        m_act_dp    = m_sh_dp;
        m_act_blank = m_sh_blank;
        m_pend      = 1'b0;
      end
      e.pend = m_pend;
      m_n++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits_in = d;
    dp_in     = p;
    blank_in  = b;
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  task automatic run_until(input int phase);
    int guard = 0;
    while ((m_n % FRAME) != phase && guard < 4 * FRAME) begin
      step();
      guard++;
    end
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = '{an: an, seg: seg, dp: dp, tick: frame_tick, pend: pending};
      check("scan{an,seg,dp,tick,pend}", 32'(a), 32'(e));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    brightness = 2'(3);
    run(3);
    rst_l = 1'b0;

    // Idle after reset: dark, no pending, frame ticks only.
    brightness = 2'($urandom_range(0, 3));
    run(2 * FRAME);

    // Basic pattern 8F10 at full brightness.
    brightness = 2'(3);
    do_load(16'h8F10, 4'b0000, 4'b0000);
    run(2 * FRAME);

    // Reduced brightness, then off.
    brightness = 2'(2);
    run(FRAME);
    brightness = 2'(0);
    run(FRAME);
    brightness = 2'(3);
    run(5);
    brightness = 2'(1);
    run(FRAME);

    // Two loads before a frame end: the second wins.
    brightness = 2'(3);
    run_until(5);
    do_load(16'hA1A2, 4'b1010, 4'b0000);
    run_until(20);
    do_load(16'hB3C4, 4'b0101, 4'b0000);
    run(2 * FRAME);

    // Load exactly on the frame-end cycle.
    run_until(FRAME - 1);
    do_load(16'hC0DE, 4'b0011, 4'b0000);
    run(2 * FRAME);

    // Blanked digit 2, decimal point on digit 0.
    do_load(16'h3456, 4'b0001, 4'b0100);
    run(2 * FRAME);

    // Randomised traffic.
    for (int c = 0; c < 20 * FRAME; c++) begin
      if ($urandom_range(0, 63) == 0) brightness = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom));
      else
        step();
    end

    // Reset in the digit 2 on-window while data is pending.
    brightness = 2'(3);
    run_until(0);
    do_load(16'h1234, 4'b0000, 4'b0000);
    run_until(0);
    do_load(16'h5678, 4'b0000, 4'b0000);
    run_until(20);
    check("pre_reset_an", 32'(an), 32'(4'b1011));
    check("pre_reset_pending", 32'(pending), 32'(1'b1));
    #5;
    rst_l = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'(4'hF));
    check("async_rst_seg", 32'(seg), 32'(7'h7F));
    check("async_rst_dp", 32'(dp), 32'(1'b1));
    check("async_rst_pending", 32'(pending), 32'(1'b0));
    check("async_rst_tick", 32'(frame_tick), 32'(1'b0));
    run(2);
    rst_l = 1'b0;
    run(FRAME);
    do_load(16'h9ABC, 4'b1000, 4'b0000);
    run(2 * FRAME + 3);

    #10;
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
